// File: rtl/mem_1r1w_arbiter.sv
// rtl/mem_1r1w_arbiter.sv - two-client arbiter with zero-fill for a 1R1W read-first registered-read macro
module mem_1r1w_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              c0_req_valid,
  output logic              c0_req_ready,
  input  logic              c0_req_write,
  input  logic [ADDR_W-1:0] c0_req_addr,
  input  logic [DATA_W-1:0] c0_req_wdata,
  output logic              c0_resp_valid,
  output logic [DATA_W-1:0] c0_resp_data,

  input  logic              c1_req_valid,
  output logic              c1_req_ready,
  input  logic              c1_req_write,
  input  logic [ADDR_W-1:0] c1_req_addr,
  input  logic [DATA_W-1:0] c1_req_wdata,
  output logic              c1_resp_valid,
  output logic [DATA_W-1:0] c1_resp_data,

  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,

  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              rd_pri_q, rd_pri_d;
  logic              wr_pri_q, wr_pri_d;
  logic              pend_valid_q, pend_valid_d;
  logic              pend_id_q, pend_id_d;

  logic rd_req0, rd_req1, wr_req0, wr_req1;
  logic rd_gnt0, rd_gnt1, wr_gnt0, wr_gnt1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= INIT;
      fill_cnt_q   <= '0;
      rd_pri_q     <= 1'b0;
      wr_pri_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      rd_pri_q     <= rd_pri_d;
      wr_pri_q     <= wr_pri_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
    end
  end

  // Read and write ports are arbitrated independently; a priority bit of 1 favours client 1.
  always_comb begin
    rd_req0 = c0_req_valid & ~c0_req_write;
    rd_req1 = c1_req_valid & ~c1_req_write;
    wr_req0 = c0_req_valid &  c0_req_write;
    wr_req1 = c1_req_valid &  c1_req_write;

    rd_gnt0 = 1'b0;
    rd_gnt1 = 1'b0;
    wr_gnt0 = 1'b0;
    wr_gnt1 = 1'b0;
    if (state_q == RUN) begin
      rd_gnt0 = rd_req0 & (~rd_req1 | ~rd_pri_q);
      rd_gnt1 = rd_req1 & (~rd_req0 |  rd_pri_q);
      wr_gnt0 = wr_req0 & (~wr_req1 | ~wr_pri_q);
      wr_gnt1 = wr_req1 & (~wr_req0 |  wr_pri_q);
    end
  end

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    rd_pri_d     = rd_pri_q;
    wr_pri_d     = wr_pri_q;
    pend_valid_d = 1'b0;
    pend_id_d    = pend_id_q;

    mem_raddr    = '0;
    mem_wen      = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;

    unique case (state_q)
      INIT: begin
        mem_wen    = 1'b1;
        mem_waddr  = fill_cnt_q;
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (fill_cnt_q == LAST_ADDR) begin
          state_d = RUN;
        end
      end

      RUN: begin
        // On contention the winner hands priority to the loser.
        if (rd_req0 && rd_req1) begin
          rd_pri_d = ~rd_pri_q;
        end
        if (wr_req0 && wr_req1) begin
          wr_pri_d = ~wr_pri_q;
        end

        if (rd_gnt0) begin
          mem_raddr = c0_req_addr;
        end else if (rd_gnt1) begin
          mem_raddr = c1_req_addr;
        end
        pend_valid_d = rd_gnt0 | rd_gnt1;
        if (rd_gnt0 | rd_gnt1) begin
          pend_id_d = rd_gnt1;
        end

        if (wr_gnt0) begin
          mem_wen   = 1'b1;
          mem_waddr = c0_req_addr;
          mem_wdata = c0_req_wdata;
        end else if (wr_gnt1) begin
          mem_wen   = 1'b1;
          mem_waddr = c1_req_addr;
          mem_wdata = c1_req_wdata;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_comb begin
    c0_req_ready  = rd_gnt0 | wr_gnt0;
    c1_req_ready  = rd_gnt1 | wr_gnt1;
    c0_resp_valid = pend_valid_q & ~pend_id_q;
    c1_resp_valid = pend_valid_q &  pend_id_q;
    c0_resp_data  = c0_resp_valid ? mem_rdata : '0;
    c1_resp_data  = c1_resp_valid ? mem_rdata : '0;
    init_done     = (state_q == RUN);
  end

endmodule

// File: tb/tb_mem_1r1w_arbiter.sv
// tb/tb_mem_1r1w_arbiter.sv - directed and randomized bench for mem_1r1w_arbiter with a macro and reference model
module tb_mem_1r1w_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 32;

  logic              clock;
  logic              reset;
  logic              c0_req_valid, c0_req_ready, c0_req_write;
  logic [ADDR_W-1:0] c0_req_addr;
  logic [DATA_W-1:0] c0_req_wdata;
  logic              c0_resp_valid;
  logic [DATA_W-1:0] c0_resp_data;
  logic              c1_req_valid, c1_req_ready, c1_req_write;
  logic [ADDR_W-1:0] c1_req_addr;
  logic [DATA_W-1:0] c1_req_wdata;
  logic              c1_resp_valid;
  logic [DATA_W-1:0] c1_resp_data;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              init_done;

  mem_1r1w_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_write(c0_req_write),
    .c0_req_addr(c0_req_addr), .c0_req_wdata(c0_req_wdata),
    .c0_resp_valid(c0_resp_valid), .c0_resp_data(c0_resp_data),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_write(c1_req_write),
    .c1_req_addr(c1_req_addr), .c1_req_wdata(c1_req_wdata),
    .c1_resp_valid(c1_resp_valid), .c1_resp_data(c1_resp_data),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .init_done(init_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural macro: registered read, read-first (old word on same-edge write).
  logic [DATA_W-1:0] macro [DEPTH];
  always @(posedge clock) begin
    mem_rdata <= macro[mem_raddr];
    if (mem_wen) macro[mem_waddr] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                in_init;
  int                fill;
  int                rd_pri, wr_pri;
  bit                exp_pend;
  int                exp_pid;
  logic [DATA_W-1:0] exp_pdata;
  bit                m_rdy0, m_rdy1;
  bit                obs_rdy0, obs_rdy1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    in_init  = 1;
    fill     = 0;
    rd_pri   = 0;
    wr_pri   = 0;
    exp_pend = 0;
    exp_pid  = 0;
    m_rdy0   = 0;
    m_rdy1   = 0;
  endtask

  task automatic drive(input bit v0, input bit w0, input int a0, input logic [63:0] d0,
                       input bit v1, input bit w1, input int a1, input logic [63:0] d1);
    c0_req_valid = v0; c0_req_write = w0; c0_req_addr = a0[ADDR_W-1:0]; c0_req_wdata = d0;
    c1_req_valid = v1; c1_req_write = w1; c1_req_addr = a1[ADDR_W-1:0]; c1_req_wdata = d1;
  endtask

  // One clock cycle: check every output against the model, advance the model, cross the edge.
  task automatic step();
    bit r0, r1, q0, q1, gr0, gr1, gw0, gw1;
    int ra, wa;
    logic [63:0] wd;
    #1;
    obs_rdy0 = c0_req_ready;
    obs_rdy1 = c1_req_ready;
    chk("c0_resp_valid", c0_resp_valid, exp_pend && exp_pid == 0);
    chk("c1_resp_valid", c1_resp_valid, exp_pend && exp_pid == 1);
    chk("c0_resp_data", c0_resp_data, (exp_pend && exp_pid == 0) ? exp_pdata : 64'h0);
    chk("c1_resp_data", c1_resp_data, (exp_pend && exp_pid == 1) ? exp_pdata : 64'h0);
    chk("init_done", init_done, !in_init);
    if (in_init) begin
      chk("init_c0_ready", c0_req_ready, 0);
      chk("init_c1_ready", c1_req_ready, 0);
      chk("init_mem_wen", mem_wen, 1);
      chk("init_mem_waddr", mem_waddr, fill);
      chk("init_mem_wdata", mem_wdata, 0);
      exp_pend = 0;
      m_rdy0 = 0;
      m_rdy1 = 0;
      fill++;
      if (fill == DEPTH) in_init = 0;
    end else begin
      r0 = c0_req_valid && !c0_req_write;
      r1 = c1_req_valid && !c1_req_write;
      q0 = c0_req_valid && c0_req_write;
      q1 = c1_req_valid && c1_req_write;
      gr0 = r0 && (!r1 || rd_pri == 0);
      gr1 = r1 && (!r0 || rd_pri == 1);
      gw0 = q0 && (!q1 || wr_pri == 0);
      gw1 = q1 && (!q0 || wr_pri == 1);
      if (r0 && r1) rd_pri = 1 - rd_pri;
      if (q0 && q1) wr_pri = 1 - wr_pri;
      ra = gr0 ? int'(c0_req_addr) : gr1 ? int'(c1_req_addr) : 0;
      wa = gw0 ? int'(c0_req_addr) : gw1 ? int'(c1_req_addr) : 0;
      wd = gw0 ? c0_req_wdata : gw1 ? c1_req_wdata : 64'h0;
      chk("c0_req_ready", c0_req_ready, gr0 || gw0);
      chk("c1_req_ready", c1_req_ready, gr1 || gw1);
      chk("mem_raddr", mem_raddr, ra);
      chk("mem_wen", mem_wen, gw0 || gw1);
      chk("mem_waddr", mem_waddr, wa);
      chk("mem_wdata", mem_wdata, wd);
      exp_pend  = gr0 || gr1;
      exp_pid   = gr1 ? 1 : 0;
      exp_pdata = ref_mem[ra];
      if (gw0 || gw1) ref_mem[wa] = wd;
      m_rdy0 = gr0 || gw0;
      m_rdy1 = gr1 || gw1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_c0_ready"}, c0_req_ready, 0);
    chk({tag, "_c1_ready"}, c1_req_ready, 0);
    chk({tag, "_c0_resp_valid"}, c0_resp_valid, 0);
    chk({tag, "_c1_resp_valid"}, c1_resp_valid, 0);
    chk({tag, "_c0_resp_data"}, c0_resp_data, 0);
    chk({tag, "_c1_resp_data"}, c1_resp_data, 0);
    chk({tag, "_init_done"}, init_done, 0);
    chk({tag, "_mem_wen"}, mem_wen, 1);
    chk({tag, "_mem_waddr"}, mem_waddr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_mem_raddr"}, mem_raddr, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) macro[i] = {$urandom, $urandom};
    mem_rdata = '0;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    // Reset values, then release between edges so the next edge is fill edge 1.
    #2;
    check_reset_values("rst");
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;

    // Zero-fill with a pending read of 17 held off until the first RUN cycle.
    drive(1, 0, 17, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) step();
    step();
    chk("rd17_valid", c0_resp_valid, 1);
    chk("rd17_data", c0_resp_data, 64'h0);

    // Write then read back by the other client.
    drive(1, 1, 5, 64'hDEADBEEF_CAFEF00D, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 1, 0, 5, 0);
    step();
    chk("wr5_c1_valid", c1_resp_valid, 1);
    chk("wr5_c1_data", c1_resp_data, 64'hDEADBEEF_CAFEF00D);
    chk("wr5_c0_valid", c0_resp_valid, 0);

    // Contended reads alternate starting with client 0.
    drive(1, 0, 1, 0, 1, 0, 2, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("alt_c0_ready", obs_rdy0, (i % 2) == 0);
      chk("alt_c1_ready", obs_rdy1, (i % 2) == 1);
    end

    // Read-first hazard on address 9.
    drive(1, 1, 9, 64'h2222, 0, 0, 0, 0);
    step();
    drive(1, 1, 9, 64'h1111, 1, 0, 9, 0);
    step();
    chk("hazard_old", c1_resp_data, 64'h2222);
    drive(0, 0, 0, 0, 1, 0, 9, 0);
    step();
    chk("hazard_new", c1_resp_data, 64'h1111);

    // Contended writes to address 3: c0 first, c1 held and granted next.
    drive(1, 1, 3, 64'hA, 1, 1, 3, 64'hB);
    step();
    chk("wr3_c0_first", obs_rdy0, 1);
    chk("wr3_c1_held", obs_rdy1, 0);
    drive(0, 0, 0, 0, 1, 1, 3, 64'hB);
    step();
    chk("wr3_c1_second", obs_rdy1, 1);
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    step();
    chk("wr3_final", c0_resp_data, 64'hB);

    // Reset in the cycle where a response is due: it is dropped and fill restarts.
    drive(0, 0, 0, 0, 1, 0, 5, 0);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_reset_values("midrst");
    @(posedge clock); #1;
    check_reset_values("midrst_hold");
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    drive(1, 0, 5, 0, 1, 0, 9, 0);
    step();
    step();
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    step();
    chk("post_rst_rd3", c0_resp_data, 64'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Randomized traffic; a request not accepted is held unchanged.
    for (int i = 0; i < 500; i++) begin
      if (!(c0_req_valid && !m_rdy0)) begin
        c0_req_valid = ($urandom_range(0, 3) != 0);
        c0_req_write = $urandom_range(0, 1);
        c0_req_addr  = ADDR_W'($urandom_range(0, 7));
        c0_req_wdata = {$urandom, $urandom};
      end
      if (!(c1_req_valid && !m_rdy1)) begin
        c1_req_valid = ($urandom_range(0, 3) != 0);
        c1_req_write = $urandom_range(0, 1);
        c1_req_addr  = ADDR_W'($urandom_range(0, 7));
        c1_req_wdata = {$urandom, $urandom};
      end
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
